// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared types for the pipeline hazard controller.
//   NREGS_DEF  - default architectural register count
//   reg_idx_t  - register index at the default register count
//   hz_state_t - redirect FSM state encoding
package pipe_pkg;
  localparam int NREGS_DEF = 32;
  localparam int RW_DEF    = $clog2(NREGS_DEF);

  typedef logic [RW_DEF-1:0] reg_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage request and hazard-control response bundle.
//   master : pipeline side, drives the ID instruction fields and ex_redirect,
//            receives stall_id / bubble_ex / flush_ifid / busy_mask
//   slave  : hazard controller side (opposite directions)
interface pipe_hazard_ctrl_if #(
  parameter int NREGS = pipe_pkg::NREGS_DEF
);
  localparam int RW = $clog2(NREGS);

  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [RW-1:0] id_rd;
  logic          id_rd_we;
  logic          id_is_load;
  logic          ex_redirect;
  logic          stall_id;
  logic          bubble_ex;
  logic          flush_ifid;
  logic [NREGS-1:0] busy_mask;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, ex_redirect,
    input  stall_id, bubble_ex, flush_ifid, busy_mask
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, ex_redirect,
    output stall_id, bubble_ex, flush_ifid, busy_mask
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: per-register pending-load counters and RAW hazard check.
//   clock, reset        - pipeline clock, async active-high reset
//   issue               - the ID instruction leaves ID this cycle
//   rd, rd_we, is_load  - destination of the issuing instruction
//   rs1/rs2, *_used     - sources of the instruction currently in ID
//   busy_mask           - bit r set while register r has a pending load
//   hazard              - a used, nonzero source is busy
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int LOAD_LAT = 1,
  localparam int RW      = $clog2(NREGS),
  localparam int CW      = $clog2(LOAD_LAT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic [RW-1:0]    rd,
  input  logic             rd_we,
  input  logic             is_load,
  input  logic [RW-1:0]    rs1,
  input  logic             rs1_used,
  input  logic [RW-1:0]    rs2,
  input  logic             rs2_used,
  output logic [NREGS-1:0] busy_mask,
  output logic             hazard
);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      // x0 is hardwired; it never carries a pending load
      assign busy_mask[r] = 1'b0;
    end else begin : g_cnt
      logic [CW-1:0] cnt_q, cnt_d;
      logic          wr;

      assign wr = issue & rd_we & (rd == RW'(r));

      // A write beats the decrement; a non-load writer clears the count
      // because its forwarded result is younger than the pending load.
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (wr)          cnt_d = is_load ? CW'(LOAD_LAT) : '0;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign busy_mask[r] = (cnt_q != '0);
    end
  end

  assign hazard = (rs1_used & (rs1 != '0) & busy_mask[rs1]) |
                  (rs2_used & (rs2 != '0) & busy_mask[rs2]);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and branch-redirect flush control.
//   clock, reset  - pipeline clock, async active-high reset
//   hz (slave)    - ID instruction fields, ex_redirect in;
//                   stall_id, bubble_ex, flush_ifid, busy_mask out
//   perf_stall_cnt, perf_flush_cnt (32b) - only when HAZARD_PERF_EN is defined
// Parameters: NREGS (register count), LOAD_LAT (1..7 load-use gap),
//             BR_PEN (1..7 IF/ID slots flushed per redirect).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int LOAD_LAT = 1,
  parameter int BR_PEN   = 2
) (
  input  logic clock,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int FW = (BR_PEN > 1) ? $clog2(BR_PEN) : 1;

  hz_state_t     state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          hazard, issue;
  logic          flush, stall;

  hazard_scoreboard #(
    .NREGS   (NREGS),
    .LOAD_LAT(LOAD_LAT)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .issue    (issue),
    .rd       (hz.id_rd),
    .rd_we    (hz.id_rd_we),
    .is_load  (hz.id_is_load),
    .rs1      (hz.id_rs1),
    .rs1_used (hz.id_rs1_used),
    .rs2      (hz.id_rs2),
    .rs2_used (hz.id_rs2_used),
    .busy_mask(hz.busy_mask),
    .hazard   (hazard)
  );

  // Redirect FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Redirect FSM: next state. The redirect cycle itself is the first flushed
  // slot, so FLUSH covers the remaining BR_PEN-1 slots and leaves on the
  // cycle whose decrement brings fcnt to zero.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.ex_redirect && BR_PEN > 1) begin
          state_d = FLUSH;
          fcnt_d  = FW'(BR_PEN - 1);
        end
      end
      FLUSH: begin
        if (hz.ex_redirect) begin
          fcnt_d = FW'(BR_PEN - 1);
        end else begin
          if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
          if (fcnt_q <= FW'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Outputs. A redirect held across reset must not leak a flush.
  always_comb begin
    flush = ~reset & (hz.ex_redirect | (state_q == FLUSH));
    stall = hz.id_valid & hazard & ~flush;
    issue = hz.id_valid & ~stall & ~flush;
  end

  assign hz.flush_ifid = flush;
  assign hz.stall_id   = stall;
  assign hz.bubble_ex  = stall | flush;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_flush_d = perf_flush_q + {31'd0, hz.ex_redirect};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=1,
// one with LOAD_LAT=3, both BR_PEN=2, sharing clock and reset.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.NREGS(32)) hz1 ();
  pipe_hazard_ctrl_if #(.NREGS(32)) hz3 ();

`ifdef HAZARD_PERF_EN
  logic [31:0] ps1, pf1, ps3, pf3;
`endif

  pipe_hazard_ctrl #(.NREGS(32), .LOAD_LAT(1), .BR_PEN(2)) u_dut1 (
    .clock(clock), .reset(reset), .hz(hz1)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
  );

  pipe_hazard_ctrl #(.NREGS(32), .LOAD_LAT(3), .BR_PEN(2)) u_dut3 (
    .clock(clock), .reset(reset), .hz(hz3)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(ps3), .perf_flush_cnt(pf3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // v, rs1, rs1_used, rs2, rs2_used, rd, rd_we, is_load, ex_redirect
  task automatic drv1(input logic v, input reg_idx_t r1, input logic u1,
                      input reg_idx_t r2, input logic u2, input reg_idx_t rd,
                      input logic we, input logic ld, input logic rdir);
    hz1.id_valid = v;  hz1.id_rs1 = r1; hz1.id_rs1_used = u1;
    hz1.id_rs2 = r2;   hz1.id_rs2_used = u2; hz1.id_rd = rd;
    hz1.id_rd_we = we; hz1.id_is_load = ld;  hz1.ex_redirect = rdir;
  endtask

  task automatic drv3(input logic v, input reg_idx_t r1, input logic u1,
                      input reg_idx_t r2, input logic u2, input reg_idx_t rd,
                      input logic we, input logic ld, input logic rdir);
    hz3.id_valid = v;  hz3.id_rs1 = r1; hz3.id_rs1_used = u1;
    hz3.id_rs2 = r2;   hz3.id_rs2_used = u2; hz3.id_rd = rd;
    hz3.id_rd_we = we; hz3.id_is_load = ld;  hz3.ex_redirect = rdir;
  endtask

  initial begin
    // Reset with a redirect asserted: nothing may leak out
    drv1(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 1);
    drv3(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    #12;
    chk("rst_busy",  64'(hz1.busy_mask), 64'h0);
    chk("rst_flush", 64'(hz1.flush_ifid), 64'h0);
    chk("rst_bub",   64'(hz1.bubble_ex), 64'h0);
    chk("rst_stall", 64'(hz1.stall_id), 64'h0);
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();

    // Load x5 then add x6,x5,x1: one stall cycle
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0); #1;
    chk("ld5_nostall", 64'(hz1.stall_id), 64'h0);
    tick();
    drv1(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); #1;
    chk("use5_stall", 64'(hz1.stall_id), 64'h1);
    chk("use5_bub",   64'(hz1.bubble_ex), 64'h1);
    chk("use5_busy",  64'(hz1.busy_mask), 64'h20);
    tick(); #1;
    chk("use5_go",    64'(hz1.stall_id), 64'h0);
    chk("use5_free",  64'(hz1.busy_mask), 64'h0);
    tick();

    // Load x0 then use x0: never busy
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    drv1(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0); #1;
    chk("x0_stall", 64'(hz1.stall_id), 64'h0);
    chk("x0_busy",  64'(hz1.busy_mask), 64'h0);
    tick();

    // Load x5 then independent use of x9,x1: no stall
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drv1(1, 5'd9, 1, 5'd1, 1, 5'd6, 1, 0, 0); #1;
    chk("indep_stall", 64'(hz1.stall_id), 64'h0);
    chk("indep_busy",  64'(hz1.busy_mask), 64'h20);
    tick();
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0); #1;
    chk("indep_clr", 64'(hz1.busy_mask), 64'h0);

    // LOAD_LAT=3: load x7 then use x7 -> three stall cycles
    drv3(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0); tick();
    drv3(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("l3_stall%0d", i), 64'(hz3.stall_id), 64'h1);
      chk($sformatf("l3_busy%0d", i),  64'(hz3.busy_mask), 64'h80);
      tick();
    end
    #1;
    chk("l3_go",   64'(hz3.stall_id), 64'h0);
    chk("l3_free", 64'(hz3.busy_mask), 64'h0);
    tick();
    drv3(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Redirect with a dependent instruction in ID: flush wins over stall,
    // and a flushed load must not mark its destination busy
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drv1(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1); #1;
    chk("rd_flush0", 64'(hz1.flush_ifid), 64'h1);
    chk("rd_stall0", 64'(hz1.stall_id), 64'h0);
    chk("rd_bub0",   64'(hz1.bubble_ex), 64'h1);
    tick();
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0); #1;
    chk("rd_flush1", 64'(hz1.flush_ifid), 64'h1);
    tick();
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0); #1;
    chk("rd_flush2", 64'(hz1.flush_ifid), 64'h0);
    chk("rd_nold9",  64'(hz1.busy_mask), 64'h0);
    tick();

    // Second pulse in the FLUSH cycle restarts the window: 3 flush cycles
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); #1;
    chk("dp_flush0", 64'(hz1.flush_ifid), 64'h1);
    tick(); #1;
    chk("dp_flush1", 64'(hz1.flush_ifid), 64'h1);
    chk("dp_stall1", 64'(hz1.stall_id), 64'h0);
    tick();
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0); #1;
    chk("dp_flush2", 64'(hz1.flush_ifid), 64'h1);
    tick(); #1;
    chk("dp_flush3", 64'(hz1.flush_ifid), 64'h0);

    // Load x3, addi x3,x3 stalls once, then a user of x3 runs freely
    drv1(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); tick();
    drv1(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 0); #1;
    chk("waw_stall", 64'(hz1.stall_id), 64'h1);
    tick(); #1;
    chk("waw_go", 64'(hz1.stall_id), 64'h0);
    tick();
    drv1(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0); #1;
    chk("waw_use",  64'(hz1.stall_id), 64'h0);
    chk("waw_busy", 64'(hz1.busy_mask), 64'h0);
    tick();
    drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);

    // LOAD_LAT=3 WAW: non-load writer clears a live count
    drv3(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); tick();
    drv3(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0); #1;
    chk("waw3_nostall", 64'(hz3.stall_id), 64'h0);
    tick();
    drv3(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0); #1;
    chk("waw3_use",  64'(hz3.stall_id), 64'h0);
    chk("waw3_busy", 64'(hz3.busy_mask), 64'h0);
    tick();

    // Reset in FLUSH with x5 pending: outputs drop in the same cycle
    drv3(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drv3(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); tick();
    drv3(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0); #1;
    chk("rf_flush", 64'(hz3.flush_ifid), 64'h1);
    chk("rf_busy",  64'(hz3.busy_mask), 64'h20);
    reset = 1'b1; #1;
    chk("rf_busy0",  64'(hz3.busy_mask), 64'h0);
    chk("rf_flush0", 64'(hz3.flush_ifid), 64'h0);
    chk("rf_bub0",   64'(hz3.bubble_ex), 64'h0);
    chk("rf_stall0", 64'(hz3.stall_id), 64'h0);
    drv3(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick(); #1;
    chk("rf_post_flush", 64'(hz3.flush_ifid), 64'h0);

    // Four load-use stalls and two redirect pulses on the LOAD_LAT=1 unit
    for (int k = 0; k < 4; k++) begin
      drv1(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
      drv1(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0); #1;
      chk($sformatf("pf_stall%0d", k), 64'(hz1.stall_id), 64'h1);
      tick(); tick();
    end
    for (int k = 0; k < 2; k++) begin
      drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); tick();
      drv1(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0); tick(); tick();
    end
`ifdef HAZARD_PERF_EN
    chk("perf_stall", 64'(ps1), 64'd4);
    chk("perf_flush", 64'(pf1), 64'd2);
`endif
    chk("end_flush", 64'(hz1.flush_ifid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
